yarvi_rf_mp: RTL and testbench

Parametrised successor of the yarvi register-file stage: a multi-read-port register file with configurable register width, register count and read-port count. It sits between fetch/decode and execute, registering the incoming instruction, PC and read addresses, and presenting read data one cycle later. On reset it clears every register through a hardware sweep, since the storage array has no reset. An optional write-to-read bypass covers same-cycle writeback hazards.

---
 rtl/yarvi_rf_mp.sv | 194 +++++++++++++++++++
 tb/tb_yarvi_rf_mp.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yarvi_rf_mp.sv
// ============================================================================
// yarvi_rf_mp -- multi-read-port register file stage
//
// This stage sits between fetch/decode and execute. It registers the incoming
// instruction, PC and read addresses. Read data is combinational from the
// registered addresses, so it appears one cycle after capture. The storage
// array has no reset. Instead, a hardware sweep writes 0 to every register
// after reset, and rf_ready rises when the sweep is done.
//
// Optional feature macro: YARVI_RF_BYPASS_EN
//   defined   : a same-cycle writeback to a register being read is forwarded
//               to out_rdata.
//   undefined : out_rdata shows the pre-write value during the writing cycle.
//
// Parameters
//   XLEN  register / write-data width
//   NREGS register count (power of two, 2..32)
//   NRD   read-port count (1..4)
//   VW    PC width
//   AW    register-address width (derived)
//
// Ports
//   clock      in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   rf_ready   out  high once the clear sweep is finished
//   in_valid   in   in_pc / in_insn / rd_addr qualify this cycle
//   in_pc      in   instruction PC
//   in_insn    in   instruction word
//   rd_addr    in   packed read addresses, port k at [k*AW +: AW]
//   stall      in   hold the output stage
//   wb_we      in   writeback enable
//   wb_rd      in   writeback address
//   wb_val     in   writeback data
//   out_valid  out  output stage holds a valid instruction
//   out_pc     out  registered in_pc
//   out_insn   out  registered in_insn
//   out_rdata  out  packed read data, port k at [k*XLEN +: XLEN]
// ============================================================================
module yarvi_rf_mp #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int VW    = 64,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  rf_ready,
    input  logic                  in_valid,
    input  logic [VW-1:0]         in_pc,
    input  logic [31:0]           in_insn,
    input  logic [NRD*AW-1:0]     rd_addr,
    input  logic                  stall,
    input  logic                  wb_we,
    input  logic [AW-1:0]         wb_rd,
    input  logic [XLEN-1:0]       wb_val,
    output logic                  out_valid,
    output logic [VW-1:0]         out_pc,
    output logic [31:0]           out_insn,
    output logic [NRD*XLEN-1:0]   out_rdata
);

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   sweep_q, sweep_d;

    // Single write port, shared by the sweep and the writeback.
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;

    logic [XLEN-1:0] regs_mem [NREGS];

    logic            out_valid_q;
    logic [VW-1:0]   out_pc_q;
    logic [31:0]     out_insn_q;
    logic [NRD*AW-1:0] rp_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_CLEAR: begin
                sweep_d = sweep_q + 1'b1;
                // NREGS is a power of two, so the last index is all ones.
                if (sweep_q == {AW{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (ready flag and write-port steering)
    // ------------------------------------------------------------------
    always_comb begin
        rf_ready = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = sweep_q;
        wr_data  = '0;
        case (state_q)
            ST_CLEAR: begin
                // The sweep owns the port, so writeback is ignored here.
                wr_en = 1'b1;
            end
            ST_RUN: begin
                rf_ready = 1'b1;
                wr_en    = wb_we && (wb_rd != '0);
                wr_addr  = wb_rd;
                wr_data  = wb_val;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage array: no reset, so the sweep is what clears it
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (wr_en) begin
            regs_mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Capture stage. It loads only in RUN, so out_valid stays 0 while
    // the sweep runs.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_insn_q  <= '0;
            rp_q        <= '0;
        end else if ((state_q == ST_RUN) && !stall) begin
            out_valid_q <= in_valid;
            out_pc_q    <= in_pc;
            out_insn_q  <= in_insn;
            rp_q        <= rd_addr;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_insn  = out_insn_q;

    // ------------------------------------------------------------------
    // Read ports. Each port re-reads the array every cycle, so a held
    // (stalled) read picks up writes committed during the stall.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   rp;
            logic [XLEN-1:0] arr_val;

            assign rp      = rp_q[gi*AW +: AW];
            assign arr_val = regs_mem[rp];
`ifdef YARVI_RF_BYPASS_EN
            logic fwd;
            assign fwd = wb_we && (state_q == ST_RUN) && (wb_rd == rp) && (rp != '0);
            assign out_rdata[gi*XLEN +: XLEN] = (rp == '0) ? '0 :
                                                fwd        ? wb_val : arr_val;
`else
            assign out_rdata[gi*XLEN +: XLEN] = (rp == '0) ? '0 : arr_val;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_yarvi_rf_mp.sv
// ============================================================================
// tb_yarvi_rf_mp -- self-checking bench for yarvi_rf_mp
//
// dut0 uses the default parameters. dut1 uses NRD=3, XLEN=32, NREGS=16.
// A behavioural model of dut0 (register array, captured stage, read
// addresses) is advanced once per rising edge once dut0 is in RUN.
// ============================================================================
module tb_yarvi_rf_mp;

    localparam int XLEN = 64, NREGS = 32, NRD = 2, VW = 64, AW = 5;
    localparam int S_XLEN = 32, S_NREGS = 16, S_NRD = 3, S_AW = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                reset_n;
    logic                rf_ready, in_valid, stall, wb_we, out_valid;
    logic [VW-1:0]       in_pc, out_pc;
    logic [31:0]         in_insn, out_insn;
    logic [NRD*AW-1:0]   rd_addr;
    logic [AW-1:0]       wb_rd;
    logic [XLEN-1:0]     wb_val;
    logic [NRD*XLEN-1:0] out_rdata;

    logic                    s_rf_ready, s_in_valid, s_stall, s_wb_we, s_out_valid;
    logic [VW-1:0]           s_in_pc, s_out_pc;
    logic [31:0]             s_in_insn, s_out_insn;
    logic [S_NRD*S_AW-1:0]   s_rd_addr;
    logic [S_AW-1:0]         s_wb_rd;
    logic [S_XLEN-1:0]       s_wb_val;
    logic [S_NRD*S_XLEN-1:0] s_out_rdata;

    yarvi_rf_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .VW(VW)) dut0 (
        .clock(clock), .reset_n(reset_n), .rf_ready(rf_ready),
        .in_valid(in_valid), .in_pc(in_pc), .in_insn(in_insn),
        .rd_addr(rd_addr), .stall(stall), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_val(wb_val), .out_valid(out_valid), .out_pc(out_pc),
        .out_insn(out_insn), .out_rdata(out_rdata)
    );

    yarvi_rf_mp #(.XLEN(S_XLEN), .NREGS(S_NREGS), .NRD(S_NRD), .VW(VW)) dut1 (
        .clock(clock), .reset_n(reset_n), .rf_ready(s_rf_ready),
        .in_valid(s_in_valid), .in_pc(s_in_pc), .in_insn(s_in_insn),
        .rd_addr(s_rd_addr), .stall(s_stall), .wb_we(s_wb_we), .wb_rd(s_wb_rd),
        .wb_val(s_wb_val), .out_valid(s_out_valid), .out_pc(s_out_pc),
        .out_insn(s_out_insn), .out_rdata(s_out_rdata)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model (dut0) ----------------
    logic [XLEN-1:0] m_regs [NREGS];
    logic            m_valid;
    logic [VW-1:0]   m_pc;
    logic [31:0]     m_insn;
    logic [AW-1:0]   m_rp [NRD];

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_valid = 1'b0;
        m_pc    = '0;
        m_insn  = '0;
        for (int k = 0; k < NRD; k++) m_rp[k] = '0;
    endfunction

    // What one rising edge in RUN does with the current inputs.
    function automatic void model_edge();
        if (wb_we && wb_rd != 0) m_regs[wb_rd] = wb_val;
        if (!stall) begin
            m_valid = in_valid;
            m_pc    = in_pc;
            m_insn  = in_insn;
            for (int k = 0; k < NRD; k++) m_rp[k] = rd_addr[k*AW +: AW];
        end
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input int k);
        logic [AW-1:0] a;
        a = m_rp[k];
        if (a == 0) return '0;
`ifdef YARVI_RF_BYPASS_EN
        if (wb_we && wb_rd == a) return wb_val;
`endif
        return m_regs[a];
    endfunction

    function automatic logic [XLEN-1:0] port(input int k);
        return out_rdata[k*XLEN +: XLEN];
    endfunction

    function automatic logic [S_XLEN-1:0] s_port(input int k);
        return s_out_rdata[k*S_XLEN +: S_XLEN];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_run();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        in_valid = 1'b1; in_pc = 64'h1111; in_insn = 32'h13;
        wb_we = 1'b1; wb_rd = 5'd3; wb_val = '1; stall = 1'b0;
        rd_addr = {5'd3, 5'd3};
        reset_n = 1'b0;
        #3;
        checks++; if (rf_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", rf_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_pc !== '0) begin errors++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        checks++; if (out_insn !== '0) begin errors++; $display("FAIL reset_insn: got %h want 0", out_insn); end
        @(negedge clock);
        reset_n = 1'b1;
        n = 0;
        while (!rf_ready && n < 100) begin
            tick();
            n++;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sweep_valid: edge %0d got %b want 0", n, out_valid); end
        end
        checks++; if (n != NREGS) begin errors++; $display("FAIL ready_edges: got %0d want %0d", n, NREGS); end
        wb_we = 1'b0; in_valid = 1'b0;
        model_reset();
        for (int a = 0; a < NREGS; a++) begin
            rd_addr = {AW'(NREGS - 1 - a), AW'(a)};
            tick_run();
            checks++; if (port(0) !== 64'd0) begin errors++; $display("FAIL clear_p0: addr %0d got %h want 0", a, port(0)); end
            checks++; if (port(1) !== 64'd0) begin errors++; $display("FAIL clear_p1: addr %0d got %h want 0", NREGS-1-a, port(1)); end
        end
        $display("test_reset done");
    endtask

    task automatic test_reset_midsweep();
        int n;
        in_valid = 1'b1;
        @(negedge clock); reset_n = 1'b0;
        @(negedge clock); reset_n = 1'b1;
        repeat (10) tick();
        reset_n = 1'b0;
        #1;
        checks++; if (rf_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b want 0", rf_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        @(negedge clock); reset_n = 1'b1;
        n = 0;
        while (!rf_ready && n < 100) begin
            tick();
            n++;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_sweep_valid: edge %0d got %b want 0", n, out_valid); end
        end
        checks++; if (n != NREGS) begin errors++; $display("FAIL mid_ready_edges: got %0d want %0d", n, NREGS); end
        in_valid = 1'b0;
        rd_addr = '0;
        model_reset();
        $display("test_reset_midsweep done");
    endtask

    task automatic test_write_read();
        wb_we = 1'b1; wb_rd = 5'd5; wb_val = 64'hDEAD_BEEF; stall = 1'b0;
        tick_run();
        wb_we = 1'b0; rd_addr = {5'd0, 5'd5};
        tick_run();
        checks++; if (port(0) !== 64'hDEAD_BEEF) begin errors++; $display("FAIL wr_r5: got %h want deadbeef", port(0)); end
        checks++; if (port(1) !== 64'd0) begin errors++; $display("FAIL wr_r0port: got %h want 0", port(1)); end
        wb_we = 1'b1; wb_rd = 5'd0; wb_val = 64'h1234;
        rd_addr = {5'd0, 5'd0};
        tick_run();
        wb_we = 1'b0;
        tick_run();
        checks++; if (port(0) !== 64'd0) begin errors++; $display("FAIL wr_r0: got %h want 0", port(0)); end
        $display("test_write_read done");
    endtask

    task automatic test_bypass();
        wb_we = 1'b1; wb_rd = 5'd7; wb_val = 64'h11;
        tick_run();
        wb_we = 1'b0; rd_addr = {5'd0, 5'd7};
        tick_run();
        checks++; if (port(0) !== 64'h11) begin errors++; $display("FAIL byp_old: got %h want 11", port(0)); end
        stall = 1'b1; wb_we = 1'b1; wb_rd = 5'd7; wb_val = 64'h55;
        #1;
`ifdef YARVI_RF_BYPASS_EN
        checks++; if (port(0) !== 64'h55) begin errors++; $display("FAIL byp_same: got %h want 55", port(0)); end
`else
        checks++; if (port(0) !== 64'h11) begin errors++; $display("FAIL byp_same: got %h want 11", port(0)); end
`endif
        tick_run();
        wb_we = 1'b0;
        #1;
        checks++; if (port(0) !== 64'h55) begin errors++; $display("FAIL byp_next: got %h want 55", port(0)); end
        stall = 1'b0;
        $display("test_bypass done");
    endtask

    task automatic test_stall();
        logic [VW-1:0]   h_pc;
        logic [31:0]     h_insn;
        logic [XLEN-1:0] w;
        in_valid = 1'b1; in_pc = {$urandom, $urandom}; in_insn = $urandom;
        rd_addr = {5'd0, 5'd9}; stall = 1'b0;
        h_pc = in_pc; h_insn = in_insn;
        tick_run();
        w = {$urandom, $urandom};
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0; in_pc = {$urandom, $urandom}; in_insn = $urandom;
            rd_addr = {5'($urandom), 5'($urandom)};
            wb_we = (i == 1); wb_rd = 5'd9; wb_val = w;
            tick_run();
            wb_we = 1'b0;
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: cyc %0d got %b want 1", i, out_valid); end
            checks++; if (out_pc !== h_pc) begin errors++; $display("FAIL stall_pc: cyc %0d got %h want %h", i, out_pc, h_pc); end
            checks++; if (out_insn !== h_insn) begin errors++; $display("FAIL stall_insn: cyc %0d got %h want %h", i, out_insn, h_insn); end
            if (i >= 1) begin
                checks++; if (port(0) !== w) begin errors++; $display("FAIL stall_rd: cyc %0d got %h want %h", i, port(0), w); end
            end
        end
        stall = 1'b0; in_valid = 1'b1; in_pc = {$urandom, $urandom}; in_insn = $urandom;
        rd_addr = {5'd9, 5'd0};
        h_pc = in_pc; h_insn = in_insn;
        tick_run();
        checks++; if (out_pc !== h_pc) begin errors++; $display("FAIL unstall_pc: got %h want %h", out_pc, h_pc); end
        checks++; if (out_insn !== h_insn) begin errors++; $display("FAIL unstall_insn: got %h want %h", out_insn, h_insn); end
        checks++; if (port(1) !== w) begin errors++; $display("FAIL unstall_rd: got %h want %h", port(1), w); end
        $display("test_stall done");
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            stall    = ($urandom_range(0, 3) == 0);
            wb_we    = $urandom_range(0, 1);
            wb_rd    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wb_val   = {$urandom, $urandom};
            in_valid = $urandom_range(0, 1);
            in_pc    = {$urandom, $urandom};
            in_insn  = $urandom;
            for (int k = 0; k < NRD; k++) rd_addr[k*AW +: AW] = 5'($urandom_range(0, 9));
            #1;
            for (int k = 0; k < NRD; k++) begin
                checks++; if (port(k) !== exp_rd(k)) begin errors++; $display("FAIL rand_rd: cyc %0d port %0d got %h want %h", c, k, port(k), exp_rd(k)); end
            end
            tick_run();
            checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rand_valid: cyc %0d got %b want %b", c, out_valid, m_valid); end
            checks++; if (out_pc !== m_pc) begin errors++; $display("FAIL rand_pc: cyc %0d got %h want %h", c, out_pc, m_pc); end
            checks++; if (out_insn !== m_insn) begin errors++; $display("FAIL rand_insn: cyc %0d got %h want %h", c, out_insn, m_insn); end
        end
        wb_we = 1'b0; stall = 1'b0;
        $display("test_random done");
    endtask

    task automatic test_small();
        logic [S_XLEN-1:0] v1, v2, v15;
        v1 = $urandom; v2 = $urandom; v15 = $urandom;
        checks++; if (s_rf_ready !== 1'b1) begin errors++; $display("FAIL small_ready: got %b want 1", s_rf_ready); end
        s_wb_we = 1'b1;
        s_wb_rd = 4'd1;  s_wb_val = v1;  tick();
        s_wb_rd = 4'd2;  s_wb_val = v2;  tick();
        s_wb_rd = 4'hF;  s_wb_val = v15; tick();
        s_wb_rd = 4'd0;  s_wb_val = 32'hABCD; tick();
        s_wb_we = 1'b0;
        s_rd_addr = {4'd15, 4'd2, 4'd1};
        tick();
        checks++; if (s_port(0) !== v1) begin errors++; $display("FAIL small_p0: got %h want %h", s_port(0), v1); end
        checks++; if (s_port(1) !== v2) begin errors++; $display("FAIL small_p1: got %h want %h", s_port(1), v2); end
        checks++; if (s_port(2) !== v15) begin errors++; $display("FAIL small_p2: got %h want %h", s_port(2), v15); end
        s_rd_addr = {4'd1, 4'd0, 4'd15};
        tick();
        checks++; if (s_port(0) !== v15) begin errors++; $display("FAIL small_p0b: got %h want %h", s_port(0), v15); end
        checks++; if (s_port(1) !== 32'd0) begin errors++; $display("FAIL small_r0: got %h want 0", s_port(1)); end
        checks++; if (s_port(2) !== v1) begin errors++; $display("FAIL small_p2b: got %h want %h", s_port(2), v1); end
        $display("test_small done");
    endtask

    initial begin
        s_in_valid = 1'b0; s_in_pc = '0; s_in_insn = '0; s_rd_addr = '0;
        s_stall = 1'b0; s_wb_we = 1'b0; s_wb_rd = '0; s_wb_val = '0;
        in_valid = 1'b0; in_pc = '0; in_insn = '0; rd_addr = '0;
        stall = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_val = '0;
        reset_n = 1'b1;
        #2;
        test_reset();
        test_reset_midsweep();
        test_write_read();
        test_bypass();
        test_stall();
        test_random();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
